// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: synchronises and qualifies the PLL lock flag, drives the PLL reset,
// and retries a bounded number of times on lock timeout before latching a fault.
module pll_lock_supervisor #(
    parameter int RST_CYCLES          = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 125000,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 8,
    localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             locked,
    output logic             pll_rst,
    output logic             pll_ready,
    output logic             fault,
    output logic [RTY_W-1:0] retry_count,
    output logic [CNT_W-1:0] lock_loss_count
);

    localparam int RC_W = $clog2(RST_CYCLES);
    localparam int SC_W = $clog2(LOCK_STABLE_CYCLES);
    localparam int TO_W = $clog2(LOCK_TIMEOUT_CYCLES);

    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RST_CYCLES - 1);
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);
    localparam logic [CNT_W-1:0] LOSS_MAX = '1;

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        DEBOUNCE,
        READY,
        FAULT
    } state_t;

    state_t state, state_d;

    logic             locked_m, locked_s;
    logic [RC_W-1:0]  rst_cnt, rst_cnt_d;
    logic [SC_W-1:0]  stb_cnt, stb_cnt_d;
    logic [TO_W-1:0]  tmr, tmr_d;
    logic [RTY_W-1:0] retry_d;
    logic [CNT_W-1:0] loss_d;
    logic             timeout, take_timeout;

    // Two-flop synchroniser; only locked_s is used past this point.
    always_ff @(posedge refclk) begin
        if (rst) begin
            locked_m <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            locked_m <= locked;
            locked_s <= locked_m;
        end
    end

    always_comb begin
        state_d      = state;
        retry_d      = retry_count;
        loss_d       = lock_loss_count;
        timeout      = (tmr == TO_LAST);
        take_timeout = 1'b0;

        unique case (state)
            RESET_PLL: if (rst_cnt == RC_LAST) state_d = WAIT_LOCK;
            WAIT_LOCK: begin
                if (timeout)       take_timeout = 1'b1;
                else if (locked_s) state_d = DEBOUNCE;
            end
            DEBOUNCE: begin
                // Qualification beats a timeout landing on the same edge.
                if (locked_s && stb_cnt == SC_LAST) begin
                    state_d = READY;
                    retry_d = '0;
                end else if (timeout) begin
                    take_timeout = 1'b1;
                end else if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end
            end
            READY: begin
                if (!locked_s) begin
                    state_d = RESET_PLL;
                    if (lock_loss_count != LOSS_MAX) loss_d = lock_loss_count + 1'b1;
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = RESET_PLL;
        endcase

        if (take_timeout) begin
            if (retry_count == RTY_MAX) begin
                state_d = FAULT;
            end else begin
                retry_d = retry_count + 1'b1;
                state_d = RESET_PLL;
            end
        end

        rst_cnt_d = (state == RESET_PLL && state_d == RESET_PLL) ? rst_cnt + 1'b1 : '0;
        stb_cnt_d = (state == DEBOUNCE && state_d == DEBOUNCE) ? stb_cnt + 1'b1 : '0;
        // Timer starts from zero when leaving RESET_PLL and is never cleared by chatter.
        tmr_d = ((state_d == WAIT_LOCK || state_d == DEBOUNCE) && state != RESET_PLL)
                ? tmr + 1'b1 : '0;
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state           <= RESET_PLL;
            rst_cnt         <= '0;
            stb_cnt         <= '0;
            tmr             <= '0;
            retry_count     <= '0;
            lock_loss_count <= '0;
            pll_rst         <= 1'b1;
            pll_ready       <= 1'b0;
            fault           <= 1'b0;
        end else begin
            state           <= state_d;
            rst_cnt         <= rst_cnt_d;
            stb_cnt         <= stb_cnt_d;
            tmr             <= tmr_d;
            retry_count     <= retry_d;
            lock_loss_count <= loss_d;
            pll_rst         <= (state_d == RESET_PLL) || (state_d == FAULT);
            pll_ready       <= (state_d == READY);
            fault           <= (state_d == FAULT);
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: deadline-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized lock/chatter/reset traffic.
module tb_pll_lock_supervisor;

    localparam int RST  = 4;
    localparam int STB  = 8;
    localparam int TMO  = 64;
    localparam int MAXR = 2;
    localparam int CW   = 4;

    logic          refclk = 1'b0;
    logic          rst    = 1'b1;
    logic          locked = 1'b0;
    logic          pll_rst, pll_ready, fault;
    logic [1:0]    retry_count;
    logic [CW-1:0] lock_loss_count;

    int tests = 0;
    int fails = 0;

    pll_lock_supervisor #(
        .RST_CYCLES(RST), .LOCK_STABLE_CYCLES(STB), .LOCK_TIMEOUT_CYCLES(TMO),
        .MAX_RETRIES(MAXR), .CNT_W(CW)
    ) dut (
        .refclk(refclk), .rst(rst), .locked(locked), .pll_rst(pll_rst),
        .pll_ready(pll_ready), .fault(fault), .retry_count(retry_count),
        .lock_loss_count(lock_loss_count)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks absolute edge numbers at which the pulse ends, the timeout
    // fires and qualification completes; the lock flag is delayed through a 2-deep queue.
    typedef enum {M_PULSE, M_SEEK, M_QUAL, M_UP, M_DEAD} mode_t;
    mode_t mode = M_PULSE;
    int    cyc = 0;
    int    pulse_end, deadline, qual_at;
    int    m_retry = 0;
    int    m_loss = 0;
    bit    m_valid = 1'b0;
    bit    sq[$];

    task automatic m_restart(input int n);
        mode      = M_PULSE;
        pulse_end = n + RST;
    endtask

    task automatic m_timeout(input int n);
        if (m_retry == MAXR) mode = M_DEAD;
        else begin
            m_retry++;
            m_restart(n);
        end
    endtask

    always @(posedge refclk) begin
        bit ls;
        cyc++;
        if (rst) begin
            m_restart(cyc);
            m_retry = 0;
            m_loss  = 0;
            sq.delete();
            sq.push_back(1'b0);
            sq.push_back(1'b0);
            m_valid = 1'b1;
        end else if (m_valid) begin
            ls = sq[0];
            case (mode)
                M_PULSE: if (cyc == pulse_end) begin mode = M_SEEK; deadline = cyc + TMO; end
                M_SEEK: begin
                    if (cyc == deadline) m_timeout(cyc);
                    else if (ls) begin mode = M_QUAL; qual_at = cyc + STB; end
                end
                M_QUAL: begin
                    if (ls && cyc == qual_at) begin mode = M_UP; m_retry = 0; end
                    else if (cyc == deadline) m_timeout(cyc);
                    else if (!ls) mode = M_SEEK;
                end
                M_UP: begin
                    if (!ls) begin
                        m_restart(cyc);
                        if (m_loss < 2**CW - 1) m_loss++;
                    end
                end
                default: ;
            endcase
            void'(sq.pop_front());
            sq.push_back(locked);
        end
    end

    always @(negedge refclk) begin
        if (m_valid) begin
            check("pll_rst", pll_rst, (mode == M_PULSE || mode == M_DEAD));
            check("pll_ready", pll_ready, (mode == M_UP));
            check("fault", fault, (mode == M_DEAD));
            check("retry_count", retry_count, m_retry);
            check("lock_loss_count", lock_loss_count, m_loss);
        end
    end

    function automatic logic sig(input int w);
        case (w)
            0:       return pll_rst;
            1:       return pll_ready;
            default: return fault;
        endcase
    endfunction

    // Counts negedges (starting with the current one) until the signal shows v.
    task automatic wait_sig(input string nm, input int w, input logic v, input int bound,
                            output int n);
        n = 0;
        while (sig(w) !== v && n < bound) begin
            @(negedge refclk);
            n++;
        end
        tests++;
        if (sig(w) !== v) begin
            fails++;
            $display("FAIL %s: got no change within %0d cycles, expected %0b", nm, bound, v);
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        locked = 1'b0;
        @(negedge refclk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, falls, run;
        logic prev;

        @(negedge refclk);
        @(negedge refclk);
        check("rst_pll_rst", pll_rst, 1);
        check("rst_pll_ready", pll_ready, 0);
        check("rst_fault", fault, 0);
        check("rst_retry", retry_count, 0);
        check("rst_loss", lock_loss_count, 0);

        // Clean lock
        rst = 1'b0;
        wait_sig("clean_pulse", 0, 0, 50, n);
        check("clean_pulse_len", n, RST);
        repeat (9) @(negedge refclk);
        locked = 1'b1;
        @(negedge refclk);
        wait_sig("clean_ready", 1, 1, 50, n);
        check("clean_ready_lat", n, STB + 2);
        check("clean_retry", retry_count, 0);
        check("clean_fault", fault, 0);

        // Loss of lock for 3 cycles, then relock
        locked = 1'b0;
        @(negedge refclk);
        wait_sig("loss_drop", 1, 0, 20, n);
        check("loss_lat", n, 2);
        check("loss_pll_rst", pll_rst, 1);
        check("loss_count", lock_loss_count, 1);
        locked = 1'b1;
        wait_sig("loss_pulse", 0, 0, 20, n);
        check("loss_pulse_len", n, RST);
        wait_sig("loss_requal", 1, 1, 50, n);
        check("loss_count_hold", lock_loss_count, 1);

        // Chatter: 5 high / 1 low never qualifies, timeout 64 cycles after pll_rst falls
        do_reset();
        wait_sig("ch_pulse", 0, 0, 50, n);
        n = 0;
        while (!pll_rst && !pll_ready && n < 300) begin
            locked = (n % 6) < 5;
            @(negedge refclk);
            n++;
        end
        check("chatter_ready", pll_ready, 0);
        check("chatter_timeout", n, TMO);
        check("chatter_retry", retry_count, 1);

        // Fault: lock never arrives
        do_reset();
        falls = 0;
        n     = 0;
        prev  = pll_rst;
        while (!fault && n < 1000) begin
            @(negedge refclk);
            n++;
            if (prev && !pll_rst) falls++;
            prev = pll_rst;
        end
        check("fault_seen", fault, 1);
        check("fault_pulses", falls, 3);
        check("fault_retry", retry_count, MAXR);
        repeat (50) @(negedge refclk);
        check("fault_hold", fault, 1);
        check("fault_hold_rst", pll_rst, 1);
        do_reset();
        check("fault_cleared", fault, 0);
        check("fault_clr_retry", retry_count, 0);

        // Saturation of the loss counter
        for (int i = 0; i < 17; i++) begin
            locked = 1'b1;
            wait_sig("sat_up", 1, 1, 100, n);
            locked = 1'b0;
            wait_sig("sat_down", 1, 0, 20, n);
        end
        check("sat_count", lock_loss_count, 15);

        // Mid-operation reset in READY
        locked = 1'b1;
        wait_sig("rdy_up", 1, 1, 100, n);
        rst = 1'b1;
        @(negedge refclk);
        check("rdy_rst_pll_rst", pll_rst, 1);
        check("rdy_rst_ready", pll_ready, 0);
        check("rdy_rst_loss", lock_loss_count, 0);
        check("rdy_rst_retry", retry_count, 0);
        rst = 1'b0;
        wait_sig("rdy_rst_pulse", 0, 0, 20, n);
        check("rdy_rst_pulse_len", n, RST);

        // Mid-operation reset in DEBOUNCE (with a nonzero loss count first)
        wait_sig("deb_up", 1, 1, 100, n);
        locked = 1'b0;
        wait_sig("deb_down", 1, 0, 20, n);
        locked = 1'b1;
        wait_sig("deb_pulse", 0, 0, 20, n);
        repeat (2) @(negedge refclk);
        rst = 1'b1;
        @(negedge refclk);
        check("deb_rst_pll_rst", pll_rst, 1);
        check("deb_rst_ready", pll_ready, 0);
        check("deb_rst_loss", lock_loss_count, 0);
        rst = 1'b0;
        wait_sig("deb_rst_pulse", 0, 0, 20, n);
        check("deb_rst_pulse_len", n, RST);

        // Randomized lock runs, chatter and occasional resets
        do_reset();
        run = 0;
        for (int c = 0; c < 4000; c++) begin
            if (run == 0) begin
                locked = ~locked;
                run    = locked ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 12));
            end
            run--;
            rst = ($urandom_range(0, 299) == 0);
            @(negedge refclk);
        end
        rst = 1'b0;
        repeat (2) @(negedge refclk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Lock supervisor for the core PLL. It runs on the free-running reference clock and drives the PLL reset. It synchronises and debounces the PLL's asynchronous `locked` output, and releases a single `pll_ready` qualifier that downstream logic uses as its reset release. On loss of lock or lock timeout it re-resets the PLL with bounded retries, then latches a fault.

## Interface
- `RST_CYCLES`, 16: number of refclk cycles `pll_rst` is held high per PLL reset pulse (≥2).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronised-lock cycles required before `pll_ready` (≥2).
- `LOCK_TIMEOUT_CYCLES`, 125000: maximum cycles from PLL reset release to qualified lock (1 ms at 125 MHz).
- `MAX_RETRIES`, 3: timeout-driven PLL re-resets allowed before fault.
- `CNT_W`, 8: width of `lock_loss_count`.
- `refclk`  in  1  reference clock, free-running, 125 MHz; sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `locked`  in  1  PLL lock indicator, asynchronous to `refclk`.
- `pll_rst`  out  1  reset to the PLL, active-high.
- `pll_ready`  out  1  high only while lock is qualified.
- `fault`  out  1  sticky; PLL failed to lock within `MAX_RETRIES` retries.
- `retry_count`  out  $clog2(MAX_RETRIES+1)  timeout retries since last qualified lock.
- `lock_loss_count`  out  CNT_W  lock losses seen in READY, saturating.

## Operation
- `locked` passes through a 2-flop synchroniser (`locked_s`). Only `locked_s` is used.
- All outputs are registered.
- Reset (`rst`=1 at an edge):
  - State becomes RESET_PLL with its counters cleared.
  - `pll_rst`=1, `pll_ready`=0, `fault`=0, `retry_count`=0, `lock_loss_count`=0.
  - Both synchroniser flops become 0.
  - `rst` mid-operation aborts any state, including FAULT.
- States:
  - RESET_PLL:
    - `pll_rst`=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK.
    - Clear the timeout timer on exit.
  - WAIT_LOCK:
    - `pll_rst`=0.
    - `locked_s`=1 goes to DEBOUNCE with the stable counter at 0.
  - DEBOUNCE:
    - The stable counter increments each cycle `locked_s`=1.
    - `locked_s`=0 returns to WAIT_LOCK. The timeout timer is not cleared, so a chattering lock cannot defeat the timeout.
    - Stable counter = LOCK_STABLE_CYCLES-1 with `locked_s`=1 goes to READY.
    - On entry to READY, clear `retry_count`.
  - READY:
    - `pll_ready`=1.
    - `locked_s`=0 goes to RESET_PLL and increments `lock_loss_count`, saturating at 2^CNT_W-1.
    - A loss does not touch `retry_count`.
  - FAULT:
    - `pll_rst`=1, `pll_ready`=0, `fault`=1.
    - Exit only via `rst`.
- Timeout:
  - The timer runs in WAIT_LOCK and DEBOUNCE.
  - Trigger: timer = LOCK_TIMEOUT_CYCLES-1.
  - If `retry_count` = MAX_RETRIES, go to FAULT. Otherwise increment `retry_count` and go to RESET_PLL.
- Simultaneous events: the DEBOUNCE→READY qualification wins over timeout on the same edge.
- Counter widths are $clog2 of their terminal values. No counter wraps.

## Timing
- Sync latency: `locked` sampled at edge 0 gives `locked_s`=1 after edge 1 and state DEBOUNCE after edge 2.
- Qualified lock: if `locked` stays high from edge 0, `pll_ready` rises on edge LOCK_STABLE_CYCLES+2.
- Loss of lock:
  - `locked` first sampled low at edge m.
  - On edge m+2: `pll_ready` falls, `pll_rst` rises, `lock_loss_count` increments.
- PLL reset pulse: `pll_rst` high for exactly RST_CYCLES edges after any entry to RESET_PLL. After `rst` deasserts, the RST_CYCLES count starts at the first edge with `rst`=0.
- Timeout: RESET_PLL is re-entered LOCK_TIMEOUT_CYCLES edges after `pll_rst` fell.
- A lock glitch shorter than 1 cycle may be missed. Any `locked_s` low in DEBOUNCE restarts qualification.

## Test plan
Bench parameters: RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=64, MAX_RETRIES=2, CNT_W=4.
- Clean lock:
  - Stimulus: release `rst`; raise `locked` 10 cycles after `pll_rst` falls.
  - Response: `pll_rst` high exactly 4 cycles; `pll_ready` rises 10 edges after `locked` first sampled high; `retry_count`=0; `fault`=0.
- Chatter:
  - Stimulus: `locked` toggles 5 high / 1 low repeatedly.
  - Response: `pll_ready` never rises; RESET_PLL re-entered 64 cycles after `pll_rst` fell; `retry_count`=1.
- Fault:
  - Stimulus: `locked` held 0.
  - Response: three PLL reset pulses; `retry_count` reaches 2; `fault`=1 and `pll_rst`=1 held indefinitely; `rst` clears `fault` to 0.
- Loss of lock:
  - Stimulus: in READY, drop `locked` for 3 cycles, then relock.
  - Response: 2 edges after the drop, `pll_ready`=0, `pll_rst`=1 for 4 cycles, `lock_loss_count`=1; then requalifies.
- Saturation:
  - Stimulus: 17 lock/loss cycles.
  - Response: `lock_loss_count` stops at 15.
- Mid-operation reset:
  - Stimulus: assert `rst` for 1 cycle in DEBOUNCE and again in READY.
  - Response: next edge shows `pll_rst`=1, `pll_ready`=0, counters 0; full 4-cycle pulse follows.
